// File: rtl/if_stage_if.sv
// Bundle of the fetch-stage handshakes: PC request side, instruction-memory
// request/response channel and the decode-facing instruction stream.
interface if_stage_if #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
);
    logic [ADDR_W-1:0]  pc_in;
    logic               pc_ready;
    logic               flush;
    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [ADDR_W-1:0]  imem_req_addr;
    logic               imem_rsp_valid;
    logic [INSTR_W-1:0] imem_rsp_data;
    logic               inst_valid;
    logic               inst_ready;
    logic [INSTR_W-1:0] inst_data;
    logic [ADDR_W-1:0]  inst_pc;

    // Fetch stage view
    modport master (
        input  pc_in, flush, imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
        output pc_ready, imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc
    );

    // Surrounding pipeline / memory view
    modport slave (
        output pc_in, flush, imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
        input  pc_ready, imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc
    );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: issues PC requests to instruction memory under a
// credit rule (one buffer slot reserved per outstanding request), tracks
// in-flight addresses, drops responses made stale by a flush and buffers
// fetched {pc, instr} pairs for decode.
module if_stage #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32,
    parameter int DEPTH   = 2
) (
    input logic       clk,
    input logic       rst,
    if_stage_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [CW-1:0]      cnt_o;
    logic [CW-1:0]      cnt_d;
    logic [CW-1:0]      cnt_c;
    logic [PW-1:0]      fl_wr;
    logic [PW-1:0]      fl_rd;
    logic [PW-1:0]      fi_wr;
    logic [PW-1:0]      fi_rd;
    logic [ADDR_W-1:0]  fl_pc   [DEPTH];
    logic [ADDR_W-1:0]  fi_pc   [DEPTH];
    logic [INSTR_W-1:0] fi_data [DEPTH];

    logic [CW:0] credit_used;
    logic        req_valid;
    logic        accept;
    logic        rsp_take;
    logic        push;
    logic        pop;

    // Request credit check and per-cycle transfer qualifiers
    always_comb begin
        credit_used = {1'b0, cnt_o} + {1'b0, cnt_c};
        req_valid   = rst && !bus.flush && (credit_used < {1'b0, DEPTH_C});
        accept      = req_valid && bus.imem_req_ready;
        rsp_take    = bus.imem_rsp_valid && (cnt_o != '0);
        push        = rsp_take && !bus.flush && (cnt_d == '0);
        pop         = (cnt_c != '0) && bus.inst_ready;
    end

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = bus.pc_in;
    assign bus.pc_ready       = accept;
    assign bus.inst_valid     = (cnt_c != '0);
    assign bus.inst_data      = fi_data[fi_rd];
    assign bus.inst_pc        = fi_pc[fi_rd];

    // In-flight address queue and outstanding-request count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fl_wr <= '0;
            fl_rd <= '0;
            cnt_o <= '0;
            fl_pc <= '{default: '0};
        end else begin
            if (accept) begin
                fl_pc[fl_wr] <= bus.pc_in;
                fl_wr        <= fl_wr + 1'b1;
            end
            if (rsp_take)
                fl_rd <= fl_rd + 1'b1;
            cnt_o <= cnt_o + CW'(accept) - CW'(rsp_take);
        end
    end

    // Stale-response drop count: loaded on flush with what is still in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt_d <= '0;
        else if (bus.flush)
            cnt_d <= cnt_o - CW'(rsp_take);
        else if (rsp_take && (cnt_d != '0))
            cnt_d <= cnt_d - 1'b1;
    end

    // Instruction buffer toward decode; flush empties it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fi_wr   <= '0;
            fi_rd   <= '0;
            cnt_c   <= '0;
            fi_pc   <= '{default: '0};
            fi_data <= '{default: '0};
        end else if (bus.flush) begin
            fi_wr <= '0;
            fi_rd <= '0;
            cnt_c <= '0;
        end else begin
            if (push) begin
                fi_pc[fi_wr]   <= fl_pc[fl_rd];
                fi_data[fi_wr] <= bus.imem_rsp_data;
                fi_wr          <= fi_wr + 1'b1;
            end
            if (pop)
                fi_rd <= fi_rd + 1'b1;
            cnt_c <= cnt_c + CW'(push) - CW'(pop);
        end
    end

`ifndef SYNTHESIS
    // A response with nothing outstanding is a memory protocol violation
    a_rsp_without_req: assert property (@(posedge clk) disable iff (!rst)
        bus.imem_rsp_valid |-> (cnt_o != '0));
    // The credit rule must keep the buffer from ever overflowing
    a_push_when_full: assert property (@(posedge clk) disable iff (!rst)
        push |-> (cnt_c != DEPTH_C));
`endif
endmodule
